// File: rtl/pspin_pkt_ingress_arb.sv
// pspin_pkt_ingress_arb
// Round-robin arbiter that funnels NUM_PORTS packet request streams
// (tag, len, valid/ready) into the packet allocator's single request port.
// Beats with an illegal length (0 or > MAX_LEN) are consumed and dropped.
// A runtime enable mask excludes ports from arbitration. Per-port grant
// counters and a global drop counter are kept.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   port_en_i         per-port enable mask (0 = never granted)
//   s_pkt_tag_i       flattened request tags, port i at [i*TAG_WIDTH +: TAG_WIDTH]
//   s_pkt_len_i       flattened request lengths, port i at [i*LEN_WIDTH +: LEN_WIDTH]
//   s_pkt_valid_i     per-port request valid
//   s_pkt_ready_o     per-port request ready (depends on valid)
//   m_pkt_tag_o       registered tag to allocator
//   m_pkt_len_o       registered length to allocator
//   m_pkt_src_o       index of the port the beat came from
//   m_pkt_valid_o     registered output valid
//   m_pkt_ready_i     allocator ready
//   grant_count_o     per-port forwarded-packet counters (wrap), 32 bits each
//   drop_count_o      illegal-length packets discarded (saturates)
module pspin_pkt_ingress_arb #(
  parameter int NUM_PORTS = 4,
  parameter int LEN_WIDTH = 20,
  parameter int TAG_WIDTH = 32,
  parameter int MAX_LEN   = 1536,
  localparam int PORT_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           port_en_i,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0] s_pkt_tag_i,
  input  logic [NUM_PORTS*LEN_WIDTH-1:0] s_pkt_len_i,
  input  logic [NUM_PORTS-1:0]           s_pkt_valid_i,
  output logic [NUM_PORTS-1:0]           s_pkt_ready_o,
  output logic [TAG_WIDTH-1:0]           m_pkt_tag_o,
  output logic [LEN_WIDTH-1:0]           m_pkt_len_o,
  output logic [PORT_WIDTH-1:0]          m_pkt_src_o,
  output logic                           m_pkt_valid_o,
  input  logic                           m_pkt_ready_i,
  output logic [NUM_PORTS*32-1:0]        grant_count_o,
  output logic [31:0]                    drop_count_o
);

  localparam int                    PW1         = PORT_WIDTH + 1;
  localparam logic [PW1-1:0]        NUM_PORTS_W = PW1'(NUM_PORTS);
  localparam logic [PORT_WIDTH-1:0] LAST_PORT   = PORT_WIDTH'(NUM_PORTS - 1);
  localparam logic [LEN_WIDTH-1:0]  MAX_LEN_W   = LEN_WIDTH'(MAX_LEN);

  logic [NUM_PORTS-1:0]  req_s;
  logic [NUM_PORTS-1:0]  grant_s;
  logic [PORT_WIDTH-1:0] gnt_idx_s;
  logic                  gnt_found_s;
  logic [PW1-1:0]        cand_s;
  logic                  load_en_s;
  logic                  hs_s;
  logic [TAG_WIDTH-1:0]  sel_tag_s;
  logic [LEN_WIDTH-1:0]  sel_len_s;
  logic                  len_legal_s;

  logic [PORT_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                  valid_q, valid_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [PORT_WIDTH-1:0] src_q, src_d;
  logic [31:0]           grant_cnt_q [NUM_PORTS];
  logic [31:0]           grant_cnt_d [NUM_PORTS];
  logic [31:0]           drop_cnt_q, drop_cnt_d;

  assign req_s     = s_pkt_valid_i & port_en_i;
  // The output register can take a new beat when empty or draining this cycle.
  assign load_en_s = !valid_q || m_pkt_ready_i;
  assign hs_s      = load_en_s && gnt_found_s;

  // Circular priority search starting at rr_ptr; first requester wins.
  always_comb begin
    grant_s     = '0;
    gnt_idx_s   = '0;
    gnt_found_s = 1'b0;
    cand_s      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand_s = {1'b0, rr_ptr_q} + PW1'(k);
      if (cand_s >= NUM_PORTS_W) begin
        cand_s = cand_s - NUM_PORTS_W;
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_found_s && req_s[cand_s[PORT_WIDTH-1:0]]) begin
        gnt_found_s                       = 1'b1;
        gnt_idx_s                         = cand_s[PORT_WIDTH-1:0];
        grant_s[cand_s[PORT_WIDTH-1:0]]   = 1'b1;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Mux the granted port's tag and length.
  always_comb begin
    sel_tag_s = '0;
    sel_len_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_idx_s == PORT_WIDTH'(i)) begin
        sel_tag_s = s_pkt_tag_i[i*TAG_WIDTH +: TAG_WIDTH];
        sel_len_s = s_pkt_len_i[i*LEN_WIDTH +: LEN_WIDTH];
      end else begin
        sel_tag_s = sel_tag_s;
      end
    end
  end

  assign len_legal_s = (sel_len_s != '0) && (sel_len_s <= MAX_LEN_W);

  // Ready is forced low during reset so no beat is consumed and lost.
  always_comb begin
    if (rst) begin
      s_pkt_ready_o = '0;
    end else if (load_en_s) begin
      s_pkt_ready_o = grant_s;
    end else begin
      s_pkt_ready_o = '0;
    end
  end

  // Next-state for pointer, output register and statistics.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    len_d       = len_q;
    src_d       = src_q;
    grant_cnt_d = grant_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    // Pointer advances past the granted port even when its beat is dropped.
    if (hs_s) begin
      rr_ptr_d = (gnt_idx_s == LAST_PORT) ? '0 : gnt_idx_s + PORT_WIDTH'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    if (load_en_s) begin
      if (hs_s && len_legal_s) begin
        valid_d                = 1'b1;
        tag_d                  = sel_tag_s;
        len_d                  = sel_len_s;
        src_d                  = gnt_idx_s;
        grant_cnt_d[gnt_idx_s] = grant_cnt_q[gnt_idx_s] + 32'd1;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
    if (hs_s && !len_legal_s && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State registers; reset drops any beat held in the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      valid_q     <= 1'b0;
      tag_q       <= '0;
      len_q       <= '0;
      src_q       <= '0;
      grant_cnt_q <= '{default: '0};
      drop_cnt_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      len_q       <= len_d;
      src_q       <= src_d;
      grant_cnt_q <= grant_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign m_pkt_valid_o = valid_q;
  assign m_pkt_tag_o   = tag_q;
  assign m_pkt_len_o   = len_q;
  assign m_pkt_src_o   = src_q;
  assign drop_count_o  = drop_cnt_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
    assign grant_count_o[g*32 +: 32] = grant_cnt_q[g];
  end

endmodule

// File: tb/tb_pspin_pkt_ingress_arb.sv
module tb_pspin_pkt_ingress_arb;

  localparam int NP = 4;
  localparam int LW = 20;
  localparam int TW = 32;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [LW-1:0] len;
    logic [1:0]    src;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    port_en;
  logic [NP*TW-1:0] s_tag;
  logic [NP*LW-1:0] s_len;
  logic [NP-1:0]    s_valid;
  logic [NP-1:0]    s_ready;
  logic [TW-1:0]    m_tag;
  logic [LW-1:0]    m_len;
  logic [1:0]       m_src;
  logic             m_valid;
  logic             m_ready;
  logic [NP*32-1:0] grant_cnt;
  logic [31:0]      drop_cnt;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  pspin_pkt_ingress_arb dut (
    .clk           (clk),
    .rst           (rst),
    .port_en_i     (port_en),
    .s_pkt_tag_i   (s_tag),
    .s_pkt_len_i   (s_len),
    .s_pkt_valid_i (s_valid),
    .s_pkt_ready_o (s_ready),
    .m_pkt_tag_o   (m_tag),
    .m_pkt_len_o   (m_len),
    .m_pkt_src_o   (m_src),
    .m_pkt_valid_o (m_valid),
    .m_pkt_ready_i (m_ready),
    .grant_count_o (grant_cnt),
    .drop_count_o  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic [TW-1:0] t, input logic [LW-1:0] l);
    s_valid[p]        = v;
    s_tag[p*TW +: TW] = t;
    s_len[p*LW +: LW] = l;
  endtask

  task automatic push(input logic [TW-1:0] t, input logic [LW-1:0] l, input logic [1:0] s);
    beat_t b;
    b.tag = t;
    b.len = l;
    b.src = s;
    exp_q.push_back(b);
  endtask

  function automatic logic [TW-1:0] ptag(input int p);
    return 32'hC0DE_0000 | TW'(p);
  endfunction

  function automatic logic [LW-1:0] plen(input int p);
    return LW'(64 + p);
  endfunction

  task automatic chk_counts(input string name, input int c0, input int c1, input int c2, input int c3);
    chk({name, "_gc0"}, 64'(grant_cnt[0*32 +: 32]), 64'(c0));
    chk({name, "_gc1"}, 64'(grant_cnt[1*32 +: 32]), 64'(c1));
    chk({name, "_gc2"}, 64'(grant_cnt[2*32 +: 32]), 64'(c2));
    chk({name, "_gc3"}, 64'(grant_cnt[3*32 +: 32]), 64'(c3));
  endtask

  task automatic all_valid(input logic v);
    for (int p = 0; p < NP; p++) set_port(p, v, ptag(p), plen(p));
  endtask

  // Monitor: every completed output handshake must match the next expected beat.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got tag %0h len %0d src %0d, expected none", m_tag, m_len, m_src);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_tag", 64'(m_tag), 64'(e.tag));
        chk("beat_len", 64'(m_len), 64'(e.len));
        chk("beat_src", 64'(m_src), 64'(e.src));
      end
    end
  end

  initial begin
    int seq5 [3];
    seq5[0] = 0; seq5[1] = 1; seq5[2] = 3;
    rst     = 1'b1;
    port_en = 4'hF;
    m_ready = 1'b1;
    s_tag   = '0;
    s_len   = '0;
    s_valid = '0;
    all_valid(1'b1);
    #3;
    // Reset state
    chk("rst_ready", 64'(s_ready), 64'h0);
    chk("rst_valid", 64'(m_valid), 64'h0);
    chk("rst_drop", 64'(drop_cnt), 64'h0);
    chk_counts("rst", 0, 0, 0, 0);
    all_valid(1'b0);
    step();
    rst = 1'b0;
    step();

    // Test 1: single beat from port 2
    set_port(2, 1'b1, 32'hA5, 20'd100);
    push(32'hA5, 20'd100, 2'd2);
    #1;
    chk("t1_ready", 64'(s_ready), 64'h4);
    chk("t1_valid_before", 64'(m_valid), 64'h0);
    step();
    set_port(2, 1'b0, 32'h0, 20'd0);
    chk("t1_valid_after", 64'(m_valid), 64'h1);
    step();
    chk("t1_valid_drop", 64'(m_valid), 64'h0);
    chk("t1_gc2", 64'(grant_cnt[2*32 +: 32]), 64'h1);

    // Test 2: fresh reset, all ports valid for 8 beats, strict round robin
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    all_valid(1'b1);
    for (int c = 0; c < 8; c++) push(ptag(c % 4), plen(c % 4), 2'(c % 4));
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("t2_ready", 64'(s_ready), 64'(4'b0001 << (c % 4)));
      step();
    end
    all_valid(1'b0);
    step();
    chk_counts("t2", 2, 2, 2, 2);

    // Test 3: stall with ports 0 and 1 valid
    set_port(0, 1'b1, ptag(0), plen(0));
    set_port(1, 1'b1, ptag(1), plen(1));
    push(ptag(0), plen(0), 2'd0);
    push(ptag(1), plen(1), 2'd1);
    step();
    m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_stall_ready", 64'(s_ready), 64'h0);
      chk("t3_stall_valid", 64'(m_valid), 64'h1);
      chk("t3_stall_tag", 64'(m_tag), 64'(ptag(0)));
      chk("t3_stall_src", 64'(m_src), 64'h0);
      step();
    end
    m_ready = 1'b1;
    #1;
    chk("t3_release_ready", 64'(s_ready), 64'h2);
    step();
    set_port(0, 1'b0, ptag(0), plen(0));
    set_port(1, 1'b0, ptag(1), plen(1));
    step();
    step();
    chk("t3_idle", 64'(m_valid), 64'h0);

    // Test 4: illegal lengths from port 3 are dropped, MAX_LEN forwarded
    set_port(3, 1'b1, 32'h30, 20'd0);
    #1;
    chk("t4_ready0", 64'(s_ready), 64'h8);
    step();
    chk("t4_drop1", 64'(drop_cnt), 64'h1);
    chk("t4_novalid1", 64'(m_valid), 64'h0);
    set_port(3, 1'b1, 32'h31, 20'd1537);
    step();
    chk("t4_drop2", 64'(drop_cnt), 64'h2);
    chk("t4_novalid2", 64'(m_valid), 64'h0);
    set_port(3, 1'b1, 32'h32, 20'd1536);
    push(32'h32, 20'd1536, 2'd3);
    step();
    set_port(3, 1'b0, 32'h0, 20'd0);
    chk("t4_valid3", 64'(m_valid), 64'h1);
    step();
    chk("t4_drop_final", 64'(drop_cnt), 64'h2);
    chk_counts("t4", 3, 3, 2, 3);

    // Test 5: port 2 masked off, 12 beats cycle over 0,1,3
    port_en = 4'b1011;
    all_valid(1'b1);
    for (int c = 0; c < 12; c++) push(ptag(seq5[c % 3]), plen(seq5[c % 3]), 2'(seq5[c % 3]));
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("t5_ready", 64'(s_ready), 64'(4'b0001 << seq5[c % 3]));
      step();
    end
    all_valid(1'b0);
    port_en = 4'hF;
    step();
    chk_counts("t5", 7, 7, 2, 7);

    // Test 6: asynchronous reset while a beat is held and stalled
    set_port(1, 1'b1, ptag(1), plen(1));
    step();
    m_ready = 1'b0;
    set_port(1, 1'b0, ptag(1), plen(1));
    step();
    chk("t6_held", 64'(m_valid), 64'h1);
    #2;
    rst = 1'b1;
    all_valid(1'b1);
    #1;
    chk("t6_rst_valid", 64'(m_valid), 64'h0);
    chk("t6_rst_tag", 64'(m_tag), 64'h0);
    chk("t6_rst_len", 64'(m_len), 64'h0);
    chk("t6_rst_src", 64'(m_src), 64'h0);
    chk("t6_rst_drop", 64'(drop_cnt), 64'h0);
    chk("t6_rst_ready", 64'(s_ready), 64'h0);
    chk_counts("t6_rst", 0, 0, 0, 0);
    step();
    rst     = 1'b0;
    m_ready = 1'b1;
    push(ptag(0), plen(0), 2'd0);
    #1;
    chk("t6_first_grant", 64'(s_ready), 64'h1);
    step();
    all_valid(1'b0);
    step();
    step();
    chk("end_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
